mig_user_emu: RTL and testbench
===============================

# mig_user_emu

Synthesizable responder for the MIG DDR user-command interface, backed by on-chip block RAM. It accepts the commands, addresses, write data and `burst_done` an initiator drives on the MIG user interface, and returns `user_cmd_ack`, `user_data_valid`, read data, `init_done` and the refresh handshake with MIG-like latencies. It substitutes for the DDR controller in simulation and in board bring-up without DRAM.

## Interface
- `MEM_ADDR_BITS`, default 10: number of stored bursts is 2^MEM_ADDR_BITS, each burst 128 bits.
- `INIT_CYCLES`, default 16: cycles from the init command to `init_done`.
- `ACK_DLY`, default 2: cycles from command accept to `user_cmd_ack` rise.
- `WDATA_DLY`, default 2: cycles from `user_cmd_ack` rise to the first write beat sample.
- `RD_LAT`, default 5: cycles from `user_cmd_ack` rise to the first `user_data_valid`.
- `REFRESH_INTERVAL`, default 512: cycles between refresh requests.
- `REFRESH_CYCLES`, default 8: duration of the refresh busy period.
- `clk0` in 1: sole clock; all logic is on the rising edge.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `user_command_register` in 3: command code. `000` nop, `010` init, `100` write, `110` read; any other code is illegal.
- `user_input_address` in 23: burst address. Bits [1:0] are ignored; the RAM index is [MEM_ADDR_BITS+1:2].
- `user_input_data` in 64: write beat.
- `user_data_mask` in 8: per-byte mask for the write beat; 1 means the byte is not written.
- `burst_done` in 1: initiator end-of-burst.
- `user_cmd_ack` out 1: command acknowledge.
- `user_output_data` out 64: read beat.
- `user_data_valid` out 1: read beat valid.
- `init_done` out 1: sticky initialization-complete flag.
- `auto_refresh_req` out 1: refresh pending.
- `ar_done` out 1: one-cycle pulse at the end of a refresh.
- `cmd_err` out 1: sticky flag, set by any illegal code sampled in IDLE.

## Operation
- States: UNINIT, INIT, IDLE, REFRESH, WR_ACK, WR_DATA, RD_ACK, RD_WAIT, RD_DATA, DRAIN.
- Reset value of every output is 0. The refresh timer and counters clear on reset. RAM contents are not reset and are retained across a reset.
- Reset mid-operation returns to UNINIT in the next cycle with all outputs 0.
- UNINIT: on `010`, go to INIT. INIT counts INIT_CYCLES, then sets `init_done` and goes to IDLE. `init_done` stays set until reset; a later `010` is ignored.
- The refresh timer counts from `init_done` and sets a pending flag each REFRESH_INTERVAL cycles.
- `auto_refresh_req` is high only while the flag is pending, the state is IDLE, and the command is `000`.
- IDLE: a nonzero legal command takes priority over a refresh expiring in the same cycle; the refresh stays pending. Otherwise, with refresh pending and command `000`, go to REFRESH.
- REFRESH: lasts REFRESH_CYCLES. At the end, pulse `ar_done` for one cycle, clear the pending flag and `auto_refresh_req`, and return to IDLE. Commands during REFRESH are not acknowledged.
- Write (`100` in IDLE): latch the address, wait ACK_DLY cycles in WR_ACK, raise `user_cmd_ack`, then enter WR_DATA.
  - Sample beat0 at WDATA_DLY cycles after the ack rise and beat1 in the following cycle.
  - Beat0 goes to RAM bits [127:64] and beat1 to [63:0], with byte enables equal to ~`user_data_mask`. Then go to DRAIN.
- Read (`110` in IDLE): latch the address, wait ACK_DLY cycles in RD_ACK, raise `user_cmd_ack`, and issue the 1-cycle RAM read.
  - RD_WAIT lasts until RD_LAT cycles after the ack rise.
  - RD_DATA holds `user_data_valid` high for exactly 2 consecutive cycles: beat0 = [127:64], beat1 = [63:0]. Then go to DRAIN.
- DRAIN: `user_cmd_ack` falls in the cycle after the command reads `000` and `burst_done` reads 0. `burst_done` must have been seen high at least once during the command. Then return to IDLE.
- If the command code changes to a different nonzero code mid-burst, set `cmd_err` and continue the original operation.

## Timing
- Write: command sampled at cycle T; ack rises at T+ACK_DLY; beats are sampled at T+ACK_DLY+WDATA_DLY and T+ACK_DLY+WDATA_DLY+1.
- Read: data is valid at T+ACK_DLY+RD_LAT and the cycle after.
- A write followed by a read of the same address returns the new data.
- Back-to-back commands: a new command is sampled no earlier than 1 cycle after the ack falls.
- `user_output_data` is registered and holds its last beat when `user_data_valid` is 0.

## Structure
- Package `mig_user_pkg` holds the command code constants (`CMD_NOP`, `CMD_INIT`, `CMD_WRITE`, `CMD_READ`) and the state enum.
- Sub-module `mig_emu_ram`: single-port memory, 2^MEM_ADDR_BITS x 128 bits, 16 byte enables, 1-cycle registered read, no reset.

## Test plan
- Init: reset, then `010` at cycle 2 -> `init_done`=1 at cycle 2+INIT_CYCLES (18); a second `010` changes nothing.
- Write/read: write 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 at address 0x000004 with mask 0, then read address 0x000004.
  - Beat0 = 0x0123456789ABCDEF and beat1 = 0xFEDCBA9876543210, on cycles T+7 and T+8.
- Mask: rewrite address 0x000004 with mask 0x0F on both beats and data all 0xFF. Read back -> upper 4 bytes of each beat are 0xFF and lower 4 bytes are unchanged.
- Refresh collision: `110` issued in the same cycle the timer expires.
  - Read completes with ack, then `auto_refresh_req`=1 after DRAIN.
  - `ar_done` pulses 8 cycles after REFRESH entry, and `auto_refresh_req` is 0 the next cycle.
- Reset mid-read: deassert `sys_rst_n` during RD_WAIT -> all outputs 0 the next cycle. After re-init, reading the earlier address returns the preserved data.
- Illegal code: `011` in IDLE -> no ack and `cmd_err`=1 held until reset.

Source files
------------

// File: rtl/mig_user_pkg.sv
// Shared command codes, FSM state encoding and helpers for the MIG user-interface emulator.
// Pulled into the other files with import mig_user_pkg::*.
package mig_user_pkg;

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_INIT  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_READ  = 3'b110;

  typedef logic [3:0] state_t;

  localparam state_t ST_UNINIT  = 4'd0;
  localparam state_t ST_INIT    = 4'd1;
  localparam state_t ST_IDLE    = 4'd2;
  localparam state_t ST_REFRESH = 4'd3;
  localparam state_t ST_WR_ACK  = 4'd4;
  localparam state_t ST_WR_DATA = 4'd5;
  localparam state_t ST_RD_ACK  = 4'd6;
  localparam state_t ST_RD_WAIT = 4'd7;
  localparam state_t ST_RD_DATA = 4'd8;
  localparam state_t ST_DRAIN   = 4'd9;

  function automatic logic cmd_is_legal(input logic [2:0] cmd);
    return (cmd == CMD_NOP) || (cmd == CMD_INIT) || (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/mig_user_emu_if.sv
// MIG DDR user-command bus between an initiator (master) and the emulator (slave).
// Signal names match the MIG user interface so existing initiators connect unchanged.
interface mig_user_emu_if;

  logic [2:0]  user_command_register;
  logic [22:0] user_input_address;
  logic [63:0] user_input_data;
  logic [7:0]  user_data_mask;
  logic        burst_done;

  logic        user_cmd_ack;
  logic [63:0] user_output_data;
  logic        user_data_valid;
  logic        init_done;
  logic        auto_refresh_req;
  logic        ar_done;
  logic        cmd_err;

  modport master (
    output user_command_register, user_input_address, user_input_data,
           user_data_mask, burst_done,
    input  user_cmd_ack, user_output_data, user_data_valid, init_done,
           auto_refresh_req, ar_done, cmd_err
  );

  modport slave (
    input  user_command_register, user_input_address, user_input_data,
           user_data_mask, burst_done,
    output user_cmd_ack, user_output_data, user_data_valid, init_done,
           auto_refresh_req, ar_done, cmd_err
  );

endinterface

// File: rtl/mig_emu_ram.sv
// Single-port burst store: one 128-bit word per burst, byte-enabled writes, 1-cycle registered read.
// Contents are deliberately not reset so data survives a controller reset.
module mig_emu_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [15:0]          be,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [127:0]         wdata,
  output logic [127:0]         rdata
);

  logic [127:0] mem_q [2**ADDR_BITS];
  logic [127:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 16; b++) begin
          if (be[b]) begin
            mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mig_user_emu.sv
// Block-RAM backed stand-in for the MIG DDR controller user interface, reproducing
// MIG-like ack, write-sample, read-latency and auto-refresh handshake timing.
module mig_user_emu
  import mig_user_pkg::*;
#(
  parameter int MEM_ADDR_BITS    = 10,
  parameter int INIT_CYCLES      = 16,
  parameter int ACK_DLY          = 2,
  parameter int WDATA_DLY        = 2,
  parameter int RD_LAT           = 5,
  parameter int REFRESH_INTERVAL = 512,
  parameter int REFRESH_CYCLES   = 8
) (
  input logic           clk0,
  input logic           sys_rst_n,
  mig_user_emu_if.slave bus
);

  localparam logic [15:0] INIT_LAST  = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] ACK_LAST   = 16'(ACK_DLY - 1);
  localparam logic [15:0] WDATA_LAST = 16'(WDATA_DLY - 1);
  localparam logic [15:0] RD_LAST    = 16'(RD_LAT - 1);
  localparam logic [15:0] RI_LAST    = 16'(REFRESH_INTERVAL - 1);
  localparam logic [15:0] RC_LAST    = 16'(REFRESH_CYCLES - 1);

  state_t                   state_q, state_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [15:0]              ref_cnt_q, ref_cnt_d;
  logic                     ref_pend_q, ref_pend_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [2:0]               op_q, op_d;
  logic                     beat_q, beat_d;
  logic                     bd_seen_q, bd_seen_d;
  logic                     ack_q, ack_d;
  logic                     valid_q, valid_d;
  logic [63:0]              rd_data_q, rd_data_d;
  logic                     init_done_q, init_done_d;
  logic                     ar_done_q, ar_done_d;
  logic                     cmd_err_q, cmd_err_d;

  logic                     ref_expire;
  logic                     in_burst;
  logic                     ram_re;
  logic                     ram_we;
  logic [15:0]              ram_be;
  logic [127:0]             ram_rdata;
  logic [2:0]               cmd;
  logic                     unused_addr_bits;

  assign cmd              = bus.user_command_register;
  assign unused_addr_bits = ^{bus.user_input_address[22:MEM_ADDR_BITS+2],
                              bus.user_input_address[1:0]};

  assign ref_expire = init_done_q && (ref_cnt_q == RI_LAST);
  assign in_burst   = state_q inside {ST_WR_ACK, ST_WR_DATA, ST_RD_ACK,
                                      ST_RD_WAIT, ST_RD_DATA, ST_DRAIN};

  // Each write beat lands directly in its half of the word, so no beat buffer is needed.
  mig_emu_ram #(
    .ADDR_BITS(MEM_ADDR_BITS)
  ) u_ram (
    .clk   (clk0),
    .en    (ram_re | (ram_we & sys_rst_n)),
    .we    (ram_we & sys_rst_n),
    .be    (ram_be),
    .addr  (addr_q),
    .wdata ({bus.user_input_data, bus.user_input_data}),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ref_cnt_d   = ref_cnt_q;
    ref_pend_d  = ref_pend_q | ref_expire;
    addr_d      = addr_q;
    op_d        = op_q;
    beat_d      = beat_q;
    bd_seen_d   = bd_seen_q;
    ack_d       = ack_q;
    valid_d     = valid_q;
    rd_data_d   = rd_data_q;
    init_done_d = init_done_q;
    ar_done_d   = 1'b0;
    cmd_err_d   = cmd_err_q;
    ram_re      = 1'b0;
    ram_we      = 1'b0;
    ram_be      = '0;

    if (init_done_q) begin
      ref_cnt_d = ref_expire ? 16'd0 : ref_cnt_q + 16'd1;
    end

    // A code switch mid-burst is flagged but the original operation runs to completion.
    if (in_burst) begin
      if (bus.burst_done) begin
        bd_seen_d = 1'b1;
      end
      if ((cmd != CMD_NOP) && (cmd != op_q)) begin
        cmd_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_UNINIT: begin
        if (cmd == CMD_INIT) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_IDLE: begin
        if ((cmd == CMD_WRITE) || (cmd == CMD_READ)) begin
          op_d      = cmd;
          addr_d    = bus.user_input_address[MEM_ADDR_BITS+1:2];
          bd_seen_d = bus.burst_done;
          cnt_d     = '0;
          state_d   = (cmd == CMD_WRITE) ? ST_WR_ACK : ST_RD_ACK;
        end else if (!cmd_is_legal(cmd)) begin
          cmd_err_d = 1'b1;
        end else if ((cmd == CMD_NOP) && ref_pend_q) begin
          cnt_d   = '0;
          state_d = ST_REFRESH;
        end
      end
      ST_REFRESH: begin
        if (cnt_q == RC_LAST) begin
          ar_done_d  = 1'b1;
          ref_pend_d = ref_expire;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WR_ACK: begin
        if (cnt_q == ACK_LAST) begin
          ack_d   = 1'b1;
          cnt_d   = '0;
          beat_d  = 1'b0;
          state_d = ST_WR_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WR_DATA: begin
        if (!beat_q) begin
          if (cnt_q == WDATA_LAST) begin
            ram_we = 1'b1;
            ram_be = {~bus.user_data_mask, 8'h00};
            beat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          ram_we  = 1'b1;
          ram_be  = {8'h00, ~bus.user_data_mask};
          beat_d  = 1'b0;
          state_d = ST_DRAIN;
        end
      end
      ST_RD_ACK: begin
        if (cnt_q == ACK_LAST) begin
          ack_d   = 1'b1;
          ram_re  = 1'b1;
          cnt_d   = '0;
          state_d = ST_RD_WAIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == RD_LAST) begin
          valid_d   = 1'b1;
          rd_data_d = ram_rdata[127:64];
          state_d   = ST_RD_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RD_DATA: begin
        valid_d   = 1'b1;
        rd_data_d = ram_rdata[63:0];
        state_d   = ST_DRAIN;
      end
      ST_DRAIN: begin
        valid_d = 1'b0;
        if ((cmd == CMD_NOP) && !bus.burst_done && bd_seen_q) begin
          ack_d     = 1'b0;
          bd_seen_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_UNINIT;
      end
    endcase
  end

  always_ff @(posedge clk0) begin
    if (!sys_rst_n) begin
      state_q     <= ST_UNINIT;
      cnt_q       <= '0;
      ref_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
      addr_q      <= '0;
      op_q        <= CMD_NOP;
      beat_q      <= 1'b0;
      bd_seen_q   <= 1'b0;
      ack_q       <= 1'b0;
      valid_q     <= 1'b0;
      rd_data_q   <= '0;
      init_done_q <= 1'b0;
      ar_done_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      beat_q      <= beat_d;
      bd_seen_q   <= bd_seen_d;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
      rd_data_q   <= rd_data_d;
      init_done_q <= init_done_d;
      ar_done_q   <= ar_done_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign bus.user_cmd_ack     = ack_q;
  assign bus.user_data_valid  = valid_q;
  assign bus.user_output_data = rd_data_q;
  assign bus.init_done        = init_done_q;
  assign bus.ar_done          = ar_done_q;
  assign bus.cmd_err          = cmd_err_q;
  assign bus.auto_refresh_req = ref_pend_q && (state_q == ST_IDLE) && (cmd == CMD_NOP);

endmodule

// File: tb/tb_mig_user_emu.sv
// Directed-plus-random bench for mig_user_emu: a byte-level memory model and the
// command-to-response latencies predict every ack, valid beat and refresh pulse.
module tb_mig_user_emu;
  import mig_user_pkg::*;

  localparam int MAB   = 10;
  localparam int INITC = 16;
  localparam int AD    = 2;
  localparam int WD    = 2;
  localparam int RL    = 5;
  localparam int RI    = 512;
  localparam int RC    = 8;

  logic clk0 = 1'b0;
  logic sys_rst_n;

  always #5 clk0 = ~clk0;

  mig_user_emu_if bus ();

  mig_user_emu #(
    .MEM_ADDR_BITS    (MAB),
    .INIT_CYCLES      (INITC),
    .ACK_DLY          (AD),
    .WDATA_DLY        (WD),
    .RD_LAT           (RL),
    .REFRESH_INTERVAL (RI),
    .REFRESH_CYCLES   (RC)
  ) dut (
    .clk0      (clk0),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int init_cyc = 0;
  logic [127:0] model [int];

  // Drive one cycle of inputs; on return, outputs reflect the edge that sampled them.
  task automatic applyStimulus(input logic [2:0] cmd, input logic [22:0] addr,
                               input logic [63:0] data, input logic [7:0] mask,
                               input logic bd);
    bus.user_command_register = cmd;
    bus.user_input_address    = addr;
    bus.user_input_data       = data;
    bus.user_data_mask        = mask;
    bus.burst_done            = bd;
    @(posedge clk0);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(CMD_NOP, 23'($urandom), {$urandom, $urandom}, 8'($urandom), 1'b0);
  endtask

  function automatic logic [22:0] mkAddr(input int idx);
    logic [22:0] a;
    a = 23'($urandom);
    a[MAB+1:2] = MAB'(idx);
    return a;
  endfunction

  function automatic void modelWrite(input int idx, input logic [63:0] b0, input logic [63:0] b1,
                                     input logic [7:0] m0, input logic [7:0] m1);
    logic [127:0] d;
    logic [15:0]  skip;
    d    = {b0, b1};
    skip = {m0, m1};
    if (!model.exists(idx)) model[idx] = '0;
    for (int j = 0; j < 16; j++) begin
      if (!skip[j]) model[idx][j*8 +: 8] = d[j*8 +: 8];
    end
  endfunction

  task automatic checkAllZero(input string tag);
    checkBit({tag, "_ack"}, bus.user_cmd_ack, 1'b0);
    checkBit({tag, "_valid"}, bus.user_data_valid, 1'b0);
    checkOutput({tag, "_rdata"}, bus.user_output_data, 64'h0);
    checkBit({tag, "_init_done"}, bus.init_done, 1'b0);
    checkBit({tag, "_arreq"}, bus.auto_refresh_req, 1'b0);
    checkBit({tag, "_ar_done"}, bus.ar_done, 1'b0);
    checkBit({tag, "_cmd_err"}, bus.cmd_err, 1'b0);
  endtask

  task automatic doInit();
    applyStimulus(CMD_INIT, 23'($urandom), 64'h0, 8'h0, 1'b0);
    for (int k = 1; k <= INITC; k++) begin
      idleCycle();
      if (k >= INITC - 1) checkBit($sformatf("init_done_k%0d", k), bus.init_done, k == INITC);
    end
    init_cyc = cyc;
  endtask

  task automatic doWrite(input int idx, input logic [63:0] b0, input logic [63:0] b1,
                         input logic [7:0] m0, input logic [7:0] m1, input logic glitch);
    logic [2:0]  c;
    logic [63:0] d;
    logic [7:0]  m;
    applyStimulus(CMD_WRITE, mkAddr(idx), {$urandom, $urandom}, 8'($urandom), 1'b0);
    checkBit("wr_ack_accept", bus.user_cmd_ack, 1'b0);
    for (int k = 1; k <= AD + WD + 2; k++) begin
      c = (k <= AD) ? CMD_WRITE : ((glitch && k == AD + 1) ? CMD_READ : CMD_NOP);
      d = {$urandom, $urandom};
      m = 8'($urandom);
      if (k == AD + WD)     begin d = b0; m = m0; end
      if (k == AD + WD + 1) begin d = b1; m = m1; end
      applyStimulus(c, 23'($urandom), d, m, k == AD + WD + 1);
      checkBit($sformatf("wr_ack_k%0d", k), bus.user_cmd_ack, (k >= AD) && (k < AD + WD + 2));
    end
    modelWrite(idx, b0, b1, m0, m1);
  endtask

  task automatic doRead(input int idx);
    logic [127:0] exp;
    exp = model[idx];
    applyStimulus(CMD_READ, mkAddr(idx), {$urandom, $urandom}, 8'($urandom), 1'b0);
    checkBit("rd_ack_accept", bus.user_cmd_ack, 1'b0);
    for (int k = 1; k <= AD + RL + 2; k++) begin
      applyStimulus((k <= AD) ? CMD_READ : CMD_NOP, 23'($urandom), {$urandom, $urandom},
                    8'($urandom), k == AD + RL);
      checkBit($sformatf("rd_ack_k%0d", k), bus.user_cmd_ack, (k >= AD) && (k < AD + RL + 2));
      checkBit($sformatf("rd_valid_k%0d", k), bus.user_data_valid,
               (k == AD + RL) || (k == AD + RL + 1));
      if (k == AD + RL) checkOutput($sformatf("rd_beat0_idx%0d", idx), bus.user_output_data, exp[127:64]);
      if (k > AD + RL)  checkOutput($sformatf("rd_beat1_idx%0d_k%0d", idx, k), bus.user_output_data, exp[63:0]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and uninitialised behaviour
    sys_rst_n = 1'b0;
    idleCycle();
    idleCycle();
    checkAllZero("reset");
    sys_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(CMD_WRITE, 23'($urandom), 64'h0, 8'h0, 1'b1);
      checkBit("uninit_no_ack", bus.user_cmd_ack, 1'b0);
    end
    idleCycle();

    doInit();

    // A second init is ignored
    applyStimulus(CMD_INIT, 23'($urandom), 64'h0, 8'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idleCycle();
      checkBit("reinit_no_ack", bus.user_cmd_ack, 1'b0);
      checkBit("reinit_init_done", bus.init_done, 1'b1);
      checkBit("reinit_cmd_err", bus.cmd_err, 1'b0);
    end

    // Directed write/read and byte-mask merge
    doWrite(1, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 8'h00, 8'h00, 1'b0);
    doRead(1);
    doWrite(1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 8'h0F, 1'b0);
    doRead(1);

    // Prefill, then random traffic against the model
    for (int i = 2; i <= 5; i++) doWrite(i, {$urandom, $urandom}, {$urandom, $urandom}, 8'h00, 8'h00, 1'b0);
    for (int n = 0; n < 12; n++) begin
      int idx;
      idx = int'($urandom_range(1, 5));
      if ($urandom_range(0, 1) == 1) doWrite(idx, {$urandom, $urandom}, {$urandom, $urandom},
                                            8'($urandom), 8'($urandom), 1'b0);
      else doRead(idx);
    end

    // Read accepted on the very edge the refresh timer expires
    while (cyc < init_cyc + RI - 1) idleCycle();
    checkBit("arreq_before_expiry", bus.auto_refresh_req, 1'b0);
    doRead(2);
    checkBit("arreq_after_drain", bus.auto_refresh_req, 1'b1);
    for (int k = 1; k <= RC + 2; k++) begin
      idleCycle();
      checkBit($sformatf("ar_done_k%0d", k), bus.ar_done, k == RC + 1);
      checkBit($sformatf("arreq_refresh_k%0d", k), bus.auto_refresh_req, 1'b0);
      checkBit($sformatf("refresh_no_ack_k%0d", k), bus.user_cmd_ack, 1'b0);
    end

    // Illegal code in IDLE
    applyStimulus(3'b011, 23'($urandom), 64'h0, 8'h0, 1'b0);
    checkBit("illegal_cmd_err", bus.cmd_err, 1'b1);
    for (int k = 0; k < 3; k++) begin
      idleCycle();
      checkBit("illegal_no_ack", bus.user_cmd_ack, 1'b0);
      checkBit("illegal_cmd_err_held", bus.cmd_err, 1'b1);
    end
    doRead(4);
    checkBit("illegal_cmd_err_after_read", bus.cmd_err, 1'b1);

    // Reset during RD_WAIT, then re-init and confirm RAM retention
    applyStimulus(CMD_READ, mkAddr(1), 64'h0, 8'h0, 1'b0);
    for (int k = 1; k <= AD + 1; k++) begin
      applyStimulus((k <= AD) ? CMD_READ : CMD_NOP, 23'($urandom), 64'h0, 8'h0, 1'b0);
    end
    checkBit("midread_ack_before_reset", bus.user_cmd_ack, 1'b1);
    sys_rst_n = 1'b0;
    idleCycle();
    checkAllZero("midread_reset");
    sys_rst_n = 1'b1;
    idleCycle();
    checkBit("post_reset_init_done", bus.init_done, 1'b0);
    doInit();
    doRead(1);
    checkBit("post_reset_cmd_err", bus.cmd_err, 1'b0);

    // Code switch mid-write flags an error but the write completes
    doWrite(3, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 8'($urandom), 1'b1);
    checkBit("glitch_cmd_err", bus.cmd_err, 1'b1);
    doRead(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
